// File: rtl/sgd_tag_dispatch.sv
// sgd_tag_dispatch: steer AXI read beats by RID to the SGD a path (whole beat) or b path (unpacked into B_WIDTH slices)
// Ports: clk, rst_n (sync active-low); started (sticky start pulse);
//   m_axi_R* read-response slave (RVALID/RDATA/RLAST/RID/RRESP in, RREADY out);
//   dispatch_axb_a_* a FIFO write (data, wr_en out; almost_full in);
//   dispatch_axb_b_* b FIFO write (data, wr_en out; almost_full in);
//   state_counters_dispatch wrapping a-stall cycle count; dispatch_drop_cnt saturating dropped-beat count.
// Option: define SGD_DISPATCH_RRESP_CHECK_EN to drop any accepted beat whose RRESP is not OKAY.
module sgd_tag_dispatch #(
  parameter int DATA_WIDTH = 512,
  parameter int ID_WIDTH   = 5,
  parameter int B_WIDTH    = 256,
  parameter int A_TAG      = 0,
  parameter int B_TAG      = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  started,
  input  logic                  m_axi_RVALID,
  input  logic [DATA_WIDTH-1:0] m_axi_RDATA,
  input  logic                  m_axi_RLAST,
  input  logic [ID_WIDTH-1:0]   m_axi_RID,
  input  logic [1:0]            m_axi_RRESP,
  output logic                  m_axi_RREADY,
  output logic [DATA_WIDTH-1:0] dispatch_axb_a_data,
  output logic                  dispatch_axb_a_wr_en,
  input  logic                  dispatch_axb_a_almost_full,
  output logic [B_WIDTH-1:0]    dispatch_axb_b_data,
  output logic                  dispatch_axb_b_wr_en,
  input  logic                  dispatch_axb_b_almost_full,
  output logic [31:0]           state_counters_dispatch,
  output logic [15:0]           dispatch_drop_cnt
);
  localparam int R  = DATA_WIDTH / B_WIDTH;
  localparam int IW = R > 1 ? $clog2(R) : 1;
  typedef enum logic {B_IDLE, B_EMIT} b_state_t;
  b_state_t b_state, b_state_nxt;
  logic started_r, a_af_r, hs, bad_resp, is_a, is_b, drop, emit, last;
  logic [IW-1:0] idx;
  logic [DATA_WIDTH-1:0] b_buf;
  logic unused_ok;
  assign unused_ok = ^{m_axi_RLAST, m_axi_RRESP};
`ifdef SGD_DISPATCH_RRESP_CHECK_EN
  assign bad_resp = m_axi_RRESP != 2'b00;
`else
  assign bad_resp = 1'b0;
`endif
  assign hs   = m_axi_RVALID & m_axi_RREADY;
  assign is_a = hs & ~bad_resp & (m_axi_RID == ID_WIDTH'(A_TAG));
  assign is_b = hs & ~bad_resp & (m_axi_RID == ID_WIDTH'(B_TAG));
  assign drop = hs & ~is_a & ~is_b;
  assign emit = (b_state == B_EMIT) & ~dispatch_axb_b_almost_full;
  assign last = idx == IW'(R - 1);
  always_ff @(posedge clk)
    if (!rst_n) b_state <= B_IDLE;
    else b_state <= b_state_nxt;
  always_comb
    b_state_nxt = b_state == B_IDLE ? (is_b ? B_EMIT : B_IDLE) : (emit & last ? B_IDLE : B_EMIT);
  // RREADY comes only from flops so it never depends combinationally on RVALID
  always_comb
    m_axi_RREADY = started_r & ~a_af_r & (b_state == B_IDLE);
  always_ff @(posedge clk)
    if (is_b) b_buf <= m_axi_RDATA;
  always_ff @(posedge clk)
    if (!rst_n) begin
      started_r               <= 1'b0;
      a_af_r                  <= 1'b0;
      idx                     <= '0;
      dispatch_axb_a_data     <= '0;
      dispatch_axb_a_wr_en    <= 1'b0;
      dispatch_axb_b_data     <= '0;
      dispatch_axb_b_wr_en    <= 1'b0;
      state_counters_dispatch <= '0;
      dispatch_drop_cnt       <= '0;
    end else begin
      started_r               <= started_r | started;
      a_af_r                  <= dispatch_axb_a_almost_full;
      dispatch_axb_a_wr_en    <= is_a;
      dispatch_axb_b_wr_en    <= emit;
      state_counters_dispatch <= state_counters_dispatch + {31'b0, a_af_r};
      if (is_a) dispatch_axb_a_data <= m_axi_RDATA;
      if (emit) begin
        dispatch_axb_b_data <= b_buf[idx*B_WIDTH +: B_WIDTH];
        idx                 <= idx + 1'b1;
      end
      if (is_b) idx <= '0;
      if (drop & ~&dispatch_drop_cnt) dispatch_drop_cnt <= dispatch_drop_cnt + 1'b1;
    end
endmodule
